// File: rtl/control_part_seq.sv
// Self-sequencing PE control part: raster-scans a W x H fmap, issues one KxK window of
// per-tap read addresses per cycle, and zero-pads the returning fmap data RD_LAT later.
module control_part_seq_tap #(
  parameter int K  = 3,
  parameter int I  = 0,
  parameter int J  = 0,
  parameter int HB = 3,
  parameter int WB = 7
)(
  input  logic [HB-1:0] r,
  input  logic [WB-1:0] c,
  input  logic [HB-1:0] h,
  input  logic [WB-1:0] w,
  input  logic          same,
  output logic [HB-1:0] row,
  output logic [WB-1:0] col,
  output logic          en
);
  localparam int P = (K-1)/2;
  logic signed [HB+1:0] rs;
  logic signed [WB+1:0] cs;

  always_comb begin
    rs  = $signed({2'b00, r}) + $signed((HB+2)'(I))
          - (same ? $signed((HB+2)'(P)) : $signed((HB+2)'(0)));
    cs  = $signed({2'b00, c}) + $signed((WB+2)'(J))
          - (same ? $signed((WB+2)'(P)) : $signed((WB+2)'(0)));
    en  = !rs[HB+1] && (rs < $signed({2'b00, h})) &&
          !cs[WB+1] && (cs < $signed({2'b00, w}));
    row = en ? rs[HB-1:0] : '0;
    col = en ? cs[WB-1:0] : '0;
  end
endmodule

module control_part_seq #(
  parameter int DW     = 8,
  parameter int K      = 3,
  parameter int NOUT   = 8,
  parameter int BW     = 16,
  parameter int WB     = 7,
  parameter int HB     = 3,
  parameter int RD_LAT = 1,
  localparam int T     = K*K
)(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WB-1:0]        cfg_w,
  input  logic [HB-1:0]        cfg_h,
  input  logic                 cfg_same,
  input  logic                 cfg_bias,
  input  logic                 pause,
  output logic                 rd_valid,
  output logic [T*HB-1:0]      rd_row,
  output logic [T*WB-1:0]      rd_col,
  output logic [T-1:0]         rd_en,
  input  logic [T*DW-1:0]      fmaps,
  input  logic [T*DW*NOUT-1:0] weights,
  input  logic [NOUT*BW-1:0]   biases,
  output logic [T*DW-1:0]      fmap,
  output logic [T*DW*NOUT-1:0] weight,
  output logic [NOUT*BW-1:0]   biasp,
  output logic                 out_valid,
  output logic [HB-1:0]        out_row,
  output logic [WB-1:0]        out_col,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} st_t;
  localparam logic [WB-1:0] KW = WB'(K);
  localparam logic [HB-1:0] KH = HB'(K);

  st_t st, st_n;
  logic [WB-1:0] w_q, w_e, c_q, cur_c, c_max, c_nx;
  logic [HB-1:0] h_q, h_e, r_q, cur_r, r_max, r_nx;
  logic          same_q, same_e, bias_q, empty, last, issue;

  logic [T-1:0][HB-1:0] row_t;
  logic [T-1:0][WB-1:0] col_t;
  logic [T-1:0]         en_t;

  logic [RD_LAT:0]              vld_pipe;
  logic [RD_LAT:0][T-1:0]       msk_pipe;
  logic [RD_LAT:0][HB-1:0]      r_pipe;
  logic [RD_LAT:0][WB-1:0]      c_pipe;
  logic [T-1:0][DW-1:0]         fmaps_a, fmap_a;

  // In IDLE the first window is issued on the start edge, so use the live cfg there.
  always_comb begin
    w_e    = (st == IDLE) ? cfg_w    : w_q;
    h_e    = (st == IDLE) ? cfg_h    : h_q;
    same_e = (st == IDLE) ? cfg_same : same_q;
    cur_r  = (st == IDLE) ? '0 : r_q;
    cur_c  = (st == IDLE) ? '0 : c_q;
    empty  = (w_e == '0) || (h_e == '0) || (!same_e && ((w_e < KW) || (h_e < KH)));
    r_max  = same_e ? h_e - HB'(1) : h_e - KH;
    c_max  = same_e ? w_e - WB'(1) : w_e - KW;
    last   = (cur_r == r_max) && (cur_c == c_max);
    c_nx   = (cur_c == c_max) ? '0 : cur_c + WB'(1);
    r_nx   = (cur_c == c_max) ? cur_r + HB'(1) : cur_r;
  end

  always_comb begin
    st_n  = st;
    issue = 1'b0;
    case (st)
      IDLE:  if (start) begin
               if (empty) st_n = DONE;
               else begin
                 issue = !pause;
                 st_n  = (!pause && last) ? DRAIN : RUN;
               end
             end
      RUN:   begin
               issue = !pause;
               if (!pause && last) st_n = DRAIN;
             end
      DRAIN: if (vld_pipe == '0) st_n = DONE;
      DONE:  st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      control_part_seq_tap #(.K(K), .I(i), .J(j), .HB(HB), .WB(WB)) u_tap (
        .r(cur_r), .c(cur_c), .h(h_e), .w(w_e), .same(same_e),
        .row(row_t[T-1-(i*K+j)]), .col(col_t[T-1-(i*K+j)]), .en(en_t[T-1-(i*K+j)])
      );
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      same_q   <= 1'b0;
      bias_q   <= 1'b0;
      r_q      <= '0;
      c_q      <= '0;
      rd_row   <= '0;
      rd_col   <= '0;
      vld_pipe <= '0;
      msk_pipe <= '0;
      r_pipe   <= '0;
      c_pipe   <= '0;
    end else begin
      st <= st_n;
      if (st == IDLE && start) begin
        w_q    <= cfg_w;
        h_q    <= cfg_h;
        same_q <= cfg_same;
        bias_q <= cfg_bias;
      end
      if (issue) begin
        r_q <= r_nx;
        c_q <= c_nx;
      end else if (st == IDLE && start) begin
        r_q <= '0;
        c_q <= '0;
      end
      rd_row      <= issue ? row_t : '0;
      rd_col      <= issue ? col_t : '0;
      vld_pipe[0] <= issue;
      msk_pipe[0] <= issue ? en_t  : '0;
      r_pipe[0]   <= issue ? cur_r : '0;
      c_pipe[0]   <= issue ? cur_c : '0;
      for (int s = 1; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        msk_pipe[s] <= msk_pipe[s-1];
        r_pipe[s]   <= r_pipe[s-1];
        c_pipe[s]   <= c_pipe[s-1];
      end
    end
  end

  assign fmaps_a = fmaps;
  for (genvar k = 0; k < T; k++) begin : g_pad
    assign fmap_a[k] = (vld_pipe[RD_LAT] && msk_pipe[RD_LAT][k]) ? fmaps_a[k] : '0;
  end

  assign rd_valid  = vld_pipe[0];
  assign rd_en     = msk_pipe[0];
  assign out_valid = vld_pipe[RD_LAT];
  assign out_row   = r_pipe[RD_LAT];
  assign out_col   = c_pipe[RD_LAT];
  assign fmap      = fmap_a;
  assign weight    = weights;
  assign biasp     = (out_valid && bias_q) ? biases : '0;
  assign busy      = (st != IDLE);
  assign done      = (st == DONE);
endmodule

// File: tb/tb_control_part_seq.sv
// Directed bench for control_part_seq: a table of whole-map runs plus a mid-run reset sequence.
module tb_control_part_seq;
  localparam int DW = 8, K = 3, NOUT = 8, BW = 16, WB = 7, HB = 3, RD_LAT = 1, T = K*K;

  logic                 clk, reset_n, start, cfg_same, cfg_bias, pause;
  logic [WB-1:0]        cfg_w;
  logic [HB-1:0]        cfg_h;
  logic                 rd_valid, out_valid, busy, done;
  logic [T*HB-1:0]      rd_row;
  logic [T*WB-1:0]      rd_col;
  logic [T-1:0]         rd_en;
  logic [T*DW-1:0]      fmaps, fmap;
  logic [T*DW*NOUT-1:0] weights, weight;
  logic [NOUT*BW-1:0]   biases, biasp;
  logic [HB-1:0]        out_row;
  logic [WB-1:0]        out_col;

  control_part_seq #(.DW(DW), .K(K), .NOUT(NOUT), .BW(BW), .WB(WB), .HB(HB), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_same(cfg_same), .cfg_bias(cfg_bias), .pause(pause), .rd_valid(rd_valid),
    .rd_row(rd_row), .rd_col(rd_col), .rd_en(rd_en), .fmaps(fmaps), .weights(weights),
    .biases(biases), .fmap(fmap), .weight(weight), .biasp(biasp), .out_valid(out_valid),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int w, h, same, bias, pause_at, pause_len, n, en_first, en_last, chk_idx, en_chk, ff;
  } vec_t;
  vec_t tbl [6];

  int checks = 0, errors = 0;
  localparam logic [T*DW-1:0] PAD00 = 72'h00000000FFFF00FFFF;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input int w, input int h, input int same, input int r, input int c,
                                output logic [T-1:0] en, output logic [T*HB-1:0] rr,
                                output logic [T*WB-1:0] cc);
    int off, row, col, t;
    logic v;
    off = same ? (K-1)/2 : 0;
    en = '0; rr = '0; cc = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        t   = i*K + j;
        row = r + i - off;
        col = c + j - off;
        v   = (row >= 0) && (row < h) && (col >= 0) && (col < w);
        en[T-1-t] = v;
        rr[(T-t)*HB-1 -: HB] = v ? HB'(row) : '0;
        cc[(T-t)*WB-1 -: WB] = v ? WB'(col) : '0;
      end
  endfunction

  function automatic logic [T*DW-1:0] mask_fm(input logic [T-1:0] en, input logic [T*DW-1:0] fm);
    logic [T*DW-1:0] o;
    o = '0;
    for (int t = 0; t < T; t++)
      o[(T-t)*DW-1 -: DW] = en[T-1-t] ? fm[(T-t)*DW-1 -: DW] : '0;
    return o;
  endfunction

  task automatic drive_fmaps(input int ff);
    logic [95:0] tmp;
    tmp   = {$urandom, $urandom, $urandom};
    fmaps = ff ? '1 : tmp[T*DW-1:0];
  endtask

  task automatic run_seq(input vec_t v);
    int k, seen, done_k, ncols, r, c, prev_r, prev_c, pleft;
    bit ptrig;
    logic exp_rdv, prev_v, ppause;
    logic [T-1:0] een, prev_en;
    logic [T*HB-1:0] err;
    logic [T*WB-1:0] ecc;
    ncols = v.same ? v.w : v.w - K + 1;
    cfg_w = WB'(v.w); cfg_h = HB'(v.h); cfg_same = v.same[0]; cfg_bias = v.bias[0];
    pause = 1'b0; drive_fmaps(v.ff); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; seen = 0; done_k = (v.n == 0) ? 1 : -1;
    prev_v = 1'b0; prev_en = '0; prev_r = 0; prev_c = 0; ppause = 1'b0; pleft = 0; ptrig = 0;
    r = 0; c = 0; een = '0;
    while (1) begin
      if (k > 200) begin
        checks++; errors++;
        $display("FAIL timeout: run w=%0d h=%0d got no done, required done", v.w, v.h);
        break;
      end
      exp_rdv = !ppause && (seen < v.n);
      chk("rd_valid", rd_valid, exp_rdv);
      if (exp_rdv) begin
        r = seen / ncols; c = seen % ncols;
        model(v.w, v.h, v.same, r, c, een, err, ecc);
        chk("rd_en", rd_en, een);
        chk("rd_row", rd_row, err);
        chk("rd_col", rd_col, ecc);
        if (seen == 0)         chk("en_first", rd_en, v.en_first);
        if (seen == v.n - 1)   chk("en_last", rd_en, v.en_last);
        if (seen == v.chk_idx) chk("en_mid", rd_en, v.en_chk);
        seen++;
        if (seen == v.n) done_k = k + 3;
      end else begin
        chk("rd_en_idle", rd_en, 0);
      end
      chk("out_valid", out_valid, prev_v);
      if (prev_v) begin
        chk("out_row", out_row, prev_r);
        chk("out_col", out_col, prev_c);
        chk("fmap", fmap, mask_fm(prev_en, fmaps));
        if (v.ff && v.same && prev_r == 0 && prev_c == 0) chk("fmap_pad00", fmap, PAD00);
      end else begin
        chk("fmap_idle", fmap, 0);
      end
      chk("biasp", biasp, (prev_v && v.bias) ? biases : '0);
      chk("done", done, k == done_k);
      chk("busy", busy, (done_k < 0) || (k <= done_k));
      if (done_k > 0 && k >= done_k + 1) break;
      prev_v = exp_rdv;
      if (exp_rdv) begin prev_en = een; prev_r = r; prev_c = c; end
      if (k == 1) begin
        cfg_w = '0; cfg_h = 3'd7; cfg_same = !v.same[0]; cfg_bias = !v.bias[0];
      end
      start = (k == 3) && (v.n > 0);
      if (!ptrig && seen == v.pause_at) begin ptrig = 1; pleft = v.pause_len; end
      pause = (pleft > 0);
      if (pleft > 0) pleft--;
      ppause = pause;
      drive_fmaps(v.ff);
      @(negedge clk);
      k++;
    end
    start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    int cnt;
    //        w  h same bias p_at p_len  n  first  last   idx  mid   ff
    tbl[0] = '{4, 4, 1, 1, -1, 0, 16, 'h01B, 'h1B0, 5, 'h1FF, 1};
    tbl[1] = '{4, 4, 0, 1, -1, 0,  4, 'h1FF, 'h1FF, 3, 'h1FF, 0};
    tbl[2] = '{4, 4, 1, 1,  9, 3, 16, 'h01B, 'h1B0, 9, 'h1FF, 0};
    tbl[3] = '{2, 4, 0, 0, -1, 0,  0, 0,     0,    -1, 0,     0};
    tbl[4] = '{5, 3, 1, 0, -1, 0, 15, 'h01B, 'h1B0, 7, 'h1FF, 0};
    tbl[5] = '{5, 3, 0, 1, -1, 0,  3, 'h1FF, 'h1FF, 1, 'h1FF, 0};

    reset_n = 1'b0; start = 1'b0; pause = 1'b0; cfg_w = '0; cfg_h = '0;
    cfg_same = 1'b0; cfg_bias = 1'b1; fmaps = '1;
    biases = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    for (int i = 0; i < T*DW*NOUT/32; i++) weights[i*32 +: 32] = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_row", rd_row, 0);
    chk("rst_rd_col", rd_col, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fmap", fmap, 0);
    chk("rst_biasp", biasp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    checks++;
    if (weight !== weights) begin errors++; $display("FAIL weight: got %0h expected %0h", weight[63:0], weights[63:0]); end
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_seq(tbl[i]);

    cfg_w = 7'd4; cfg_h = 3'd4; cfg_same = 1'b1; cfg_bias = 1'b1; fmaps = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cnt = 0;
    for (int n = 0; n < 40 && cnt < 5; n++) begin
      if (rd_valid) cnt++;
      if (cnt < 5) @(negedge clk);
    end
    chk("abort_reached", cnt, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_rd_row", rd_row, 0);
    chk("abort_rd_col", rd_col, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_fmap", fmap, 0);
    chk("abort_biasp", biasp, 0);
    chk("abort_busy", busy, 0);
    for (int n = 0; n < 3; n++) begin
      chk("abort_done", done, 0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_done", done, 0);
    chk("abort_idle_busy", busy, 0);
    run_seq(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
